// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch sequencer: default widths and FSM state encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fetch_ctrl_pkg;

    localparam int FETCH_WIDTH = 16;
    localparam int FETCH_DEPTH = 2;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/fetch_ctrl_if.sv
// PC control, ROM address/data, jump and decoder handshake bundle for fetch_ctrl.
// Latency: n/a (wiring only).
// Backpressure: instr_valid/instr_ready carried as-is.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = FETCH_WIDTH
);

    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_in;
    logic             pc_load;
    logic             pc_inc;
    logic             pc_reset;
    logic [WIDTH-1:0] rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic             jump_req;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic             instr_valid;
    logic             instr_ready;

    modport master (
        input  pc_out, rom_data, jump_req, jump_target, instr_ready,
        output pc_in, pc_load, pc_inc, pc_reset, rom_addr,
               instr, instr_pc, instr_valid
    );

    modport slave (
        output pc_out, rom_data, jump_req, jump_target, instr_ready,
        input  pc_in, pc_load, pc_inc, pc_reset, rom_addr,
               instr, instr_pc, instr_valid
    );

endinterface

// File: rtl/fetch_ctrl_ibuf.sv
// Generic DEPTH-entry synchronous FIFO with flush; holds {addr, data} fetch entries.
// Latency: a push is visible at head the cycle after the write edge.
// Backpressure: caller must not push when full without a same-cycle pop; flush beats push.
module fetch_ctrl_ibuf #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset: empty masks head downstream.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: brings up the PC, issues ROM reads, buffers tagged instructions for the decoder.
// Latency: first instr_valid 3 cycles after INIT or after a jump; 1 instr/cycle steady state.
// Backpressure: instr_ready low stalls issue once buffer plus in-flight read reaches DEPTH.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = FETCH_WIDTH,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic         clock,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [0:0]         state;
    logic               inflight;
    logic [WIDTH-1:0]   inflight_addr;
    logic               run;
    logic               pop;
    logic               jump;
    logic               issue;
    logic               push;
    logic               full;
    logic               empty;
    logic [CW-1:0]      count;
    logic [CW:0]        occ;
    logic [2*WIDTH-1:0] head;

    assign run  = (state == ST_RUN);
    assign pop  = bus.instr_valid & bus.instr_ready;
    assign jump = run & bus.jump_req;

    // Slots committed after this edge: buffered entries plus the read still in flight.
    assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue = run & ~bus.jump_req & ~(full & ~pop) & (occ < (CW+1)'(DEPTH));

    // A jump discards the read issued last cycle rather than capturing it.
    assign push = inflight & ~jump;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_INIT;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            state    <= ST_RUN;
            inflight <= issue;
            if (issue) inflight_addr <= bus.pc_out;
        end
    end

    fetch_ctrl_ibuf #(
        .W     (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat ({inflight_addr, bus.rom_data}),
        .pop      (pop),
        .flush    (jump),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign bus.pc_reset    = ~run;
    assign bus.pc_load     = jump;
    assign bus.pc_in       = jump ? bus.jump_target : '0;
    assign bus.pc_inc      = issue;
    assign bus.rom_addr    = bus.pc_out;
    assign bus.instr_valid = ~empty;
    assign bus.instr_pc    = empty ? '0 : head[2*WIDTH-1:WIDTH];
    assign bus.instr       = empty ? '0 : head[WIDTH-1:0];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with a PC register and a registered ROM (mem[a] = 0x1000 + a).
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int DEPTH = 2;
    localparam int NVEC  = 23;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_ctrl_if #(.WIDTH(16)) bus();

    fetch_ctrl #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [15:0] pc;
    always @(posedge clock) begin
        if (bus.pc_reset)     pc <= 16'h0000;
        else if (bus.pc_load) pc <= bus.pc_in;
        else if (bus.pc_inc)  pc <= pc + 16'd1;
    end
    assign bus.pc_out = pc;

    always @(posedge clock) bus.rom_data <= bus.rom_addr + 16'h1000;

    typedef struct {
        logic        rdy;
        logic        jmp;
        logic [15:0] tgt;
        logic        vld;
        logic [15:0] ins;
        logic [15:0] ipc;
        logic        inc;
        logic        load;
        logic        prst;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(logic rdy, logic jmp, logic [15:0] tgt, logic vld,
                                logic [15:0] ins, logic [15:0] ipc,
                                logic inc, logic load, logic prst);
        vec_t v;
        v.rdy = rdy; v.jmp = jmp; v.tgt = tgt; v.vld = vld; v.ins = ins;
        v.ipc = ipc; v.inc = inc; v.load = load; v.prst = prst;
        return v;
    endfunction

    function automatic logic [63:0] snap();
        return 64'({bus.instr_valid, bus.instr, bus.instr_pc,
                    bus.pc_inc, bus.pc_load, bus.pc_reset, bus.pc_in});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rdy, input logic jmp, input logic [15:0] tgt);
        bus.instr_ready = rdy;
        bus.jump_req    = jmp;
        bus.jump_target = tgt;
    endtask

    initial begin
        logic [63:0] ev;
        logic [15:0] exp_addr;
        logic [15:0] ev16;
        logic [15:0] tgt;
        logic        rdy, jmp, pop;
        logic        p_vld, p_pop, p_jmp;
        logic [15:0] p_instr, p_ipc;
        int          outst, since_j;
        bit          synced;

        // Row 0 is the INIT cycle: its jump must be ignored.
        vecs[0]  = mk(1, 1, 16'h0050, 0, 16'h0000, 16'h0000, 0, 0, 1);
        vecs[1]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[2]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[3]  = mk(0, 0, 16'h0000, 1, 16'h1000, 16'h0000, 0, 0, 0);
        vecs[4]  = mk(0, 0, 16'h0000, 1, 16'h1000, 16'h0000, 0, 0, 0);
        vecs[5]  = mk(0, 0, 16'h0000, 1, 16'h1000, 16'h0000, 0, 0, 0);
        vecs[6]  = mk(0, 0, 16'h0000, 1, 16'h1000, 16'h0000, 0, 0, 0);
        vecs[7]  = mk(0, 0, 16'h0000, 1, 16'h1000, 16'h0000, 0, 0, 0);
        vecs[8]  = mk(1, 0, 16'h0000, 1, 16'h1000, 16'h0000, 1, 0, 0);
        vecs[9]  = mk(1, 0, 16'h0000, 1, 16'h1001, 16'h0001, 1, 0, 0);
        vecs[10] = mk(0, 0, 16'h0000, 1, 16'h1002, 16'h0002, 0, 0, 0);
        vecs[11] = mk(0, 1, 16'h0040, 1, 16'h1002, 16'h0002, 0, 1, 0);
        vecs[12] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[13] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[14] = mk(1, 0, 16'h0000, 1, 16'h1040, 16'h0040, 1, 0, 0);
        vecs[15] = mk(1, 0, 16'h0000, 1, 16'h1041, 16'h0041, 1, 0, 0);
        vecs[16] = mk(1, 1, 16'hFFFE, 1, 16'h1042, 16'h0042, 0, 1, 0);
        vecs[17] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[18] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[19] = mk(1, 0, 16'h0000, 1, 16'h0FFE, 16'hFFFE, 1, 0, 0);
        vecs[20] = mk(1, 0, 16'h0000, 1, 16'h0FFF, 16'hFFFF, 1, 0, 0);
        vecs[21] = mk(1, 0, 16'h0000, 1, 16'h1000, 16'h0000, 1, 0, 0);
        vecs[22] = mk(1, 0, 16'h0000, 1, 16'h1001, 16'h0001, 1, 0, 0);

        drive(1'b1, 1'b0, 16'h0000);
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        drive(1'b1, 1'b1, 16'h1234);
        #1;
        ev = 64'({1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000});
        chk("reset_state", snap(), ev);

        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            drive(vecs[i].rdy, vecs[i].jmp, vecs[i].tgt);
            #1;
            ev = 64'({vecs[i].vld, vecs[i].ins, vecs[i].ipc, vecs[i].inc, vecs[i].load,
                      vecs[i].prst, (vecs[i].load ? vecs[i].tgt : 16'h0000)});
            chk($sformatf("vec_row%0d", i), snap(), ev);
        end

        // Random traffic against an address-stream scoreboard.
        synced = 1'b0; since_j = 99; outst = 0; exp_addr = 16'h0000;
        p_vld = 1'b0; p_pop = 1'b0; p_jmp = 1'b0; p_instr = '0; p_ipc = '0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clock);
            jmp = (n == 0) || ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 3))
                                              : 16'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            drive(rdy, jmp, tgt);
            #1;
            pop = bus.instr_valid & rdy;
            if (synced) begin
                if (p_vld && !p_pop && !p_jmp) begin
                    chk("hold_vld", 64'(bus.instr_valid), 64'(1'b1));
                    chk("hold_instr", 64'(bus.instr), 64'(p_instr));
                    chk("hold_pc", 64'(bus.instr_pc), 64'(p_ipc));
                end
                if (since_j == 1 || since_j == 2) chk("jump_gap", 64'(bus.instr_valid), 64'(1'b0));
                if (since_j == 3) chk("jump_latency", 64'(bus.instr_valid), 64'(1'b1));
                chk("inc_rule", 64'(bus.pc_inc), 64'(!jmp && (outst - int'(pop) < DEPTH)));
                if (pop) begin
                    ev16 = exp_addr + 16'h1000;
                    chk("pop_pc", 64'(bus.instr_pc), 64'(exp_addr));
                    chk("pop_instr", 64'(bus.instr), 64'(ev16));
                    exp_addr = exp_addr + 16'd1;
                end
            end
            chk("load_excl", 64'(bus.pc_load & bus.pc_inc), 64'(1'b0));
            chk("load", 64'(bus.pc_load), 64'(jmp));
            ev16 = jmp ? tgt : 16'h0000;
            chk("pc_in", 64'(bus.pc_in), 64'(ev16));
            chk("pc_reset_run", 64'(bus.pc_reset), 64'(1'b0));
            if (jmp) begin
                exp_addr = tgt; outst = 0; since_j = 1; synced = 1'b1;
            end else begin
                outst = outst + int'(bus.pc_inc) - int'(pop);
                since_j++;
                chk("occupancy", 64'(outst <= DEPTH), 64'(1'b1));
            end
            p_vld = bus.instr_valid; p_pop = pop; p_jmp = jmp;
            p_instr = bus.instr; p_ipc = bus.instr_pc;
        end

        // Asynchronous reset between edges, then a clean restart from address 0.
        @(negedge clock);
        drive(1'b1, 1'b1, 16'h1234);
        #2 reset = 1'b0;
        #1;
        ev = 64'({1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000});
        chk("async_reset", snap(), ev);
        drive(1'b1, 1'b0, 16'h0000);
        repeat (2) @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            #1;
            ev16 = (k >= 3) ? 16'(k - 3) : 16'h0000;
            chk("restart_pc_reset", 64'(bus.pc_reset), 64'(k == 0));
            chk("restart_vld", 64'(bus.instr_valid), 64'(k >= 3));
            chk("restart_pc", 64'(bus.instr_pc), 64'(ev16));
            ev16 = (k >= 3) ? 16'h1000 + 16'(k - 3) : 16'h0000;
            chk("restart_instr", 64'(bus.instr), 64'(ev16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
